// File: rtl/traffic_pkg.sv
// Shared types and defaults for the traffic light timer.
package traffic_pkg;

  localparam int unsigned CNT_W          = 7;
  localparam int unsigned DEF_CYCLE_LEN  = 100;
  localparam int unsigned DEF_SHORTEN_TO = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FREEZE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    COL_RED    = 2'd0,
    COL_YELLOW = 2'd1,
    COL_GREEN  = 2'd2,
    COL_OFF    = 2'd3
  } color_e;

  // Countdown value loaded at reset, clear and wrap.
  function automatic logic [CNT_W-1:0] reload_val(input int unsigned cycle_len);
    return CNT_W'(cycle_len - 1);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every CLK_DIV cycles spent running.
module tick_gen #(
  parameter int unsigned CLK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic zero,
  output logic tick
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // Next prescale count: zero wins, otherwise count only while running.
  always_comb begin
    cnt_d = cnt_q;
    if (zero) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  // Prescale count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && !zero && (cnt_q == LAST);

endmodule

// File: rtl/traffic_timer.sv
// Traffic light cycle timer with pedestrian shortening.
module traffic_timer
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 100_000_000,
  parameter int unsigned CYCLE_LEN  = DEF_CYCLE_LEN,
  parameter int unsigned SHORTEN_TO = DEF_SHORTEN_TO
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             walk_req,
  output logic [CNT_W-1:0] countdown,
  output logic             wrap,
  output logic             walk_ack
);

  localparam logic [CNT_W-1:0] RELOAD = reload_val(CYCLE_LEN);
  localparam logic [CNT_W-1:0] SHORT  = CNT_W'(SHORTEN_TO);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cd_q, cd_d;
  logic             pend_q, pend_d;
  logic             wrap_q, wrap_d;
  logic             ack_q, ack_d;
  logic             tick;
  logic             presc_run;
  logic             presc_zero;

  assign presc_run  = (state_q == ST_RUN);
  assign presc_zero = clr || (state_q == ST_IDLE);

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (presc_run),
    .zero  (presc_zero),
    .tick  (tick)
  );

  // Next state, countdown, pending request and pulse outputs.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    pend_d  = pend_q;
    wrap_d  = 1'b0;
    ack_d   = 1'b0;

    if (clr) begin
      state_d = ST_IDLE;
      cd_d    = RELOAD;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (en)  state_d = ST_RUN;
        ST_RUN:    if (!en) state_d = ST_FREEZE;
        ST_FREEZE: if (en)  state_d = ST_RUN;
        default:            state_d = ST_IDLE;
      endcase

      if (walk_req && (state_q != ST_IDLE)) begin
        pend_d = 1'b1;
      end

      // Wrap beats shorten; a shorten consumes the request, including one arriving now.
      if (tick) begin
        if (cd_q == '0) begin
          cd_d   = RELOAD;
          wrap_d = 1'b1;
        end else if (pend_q && (cd_q > SHORT)) begin
          cd_d   = SHORT;
          pend_d = 1'b0;
          ack_d  = 1'b1;
        end else begin
          cd_d = cd_q - CNT_W'(1);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cd_q    <= RELOAD;
      pend_q  <= 1'b0;
      wrap_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      pend_q  <= pend_d;
      wrap_q  <= wrap_d;
      ack_q   <= ack_d;
    end
  end

  assign countdown = cd_q;
  assign wrap      = wrap_q;
  assign walk_ack  = ack_q;

endmodule

// File: doc/traffic_timer.md
TRAFFIC_TIMER -- requirements
Module: traffic_timer

Interface
REQ-001 Parameter CLK_DIV, default 100_000_000; clk cycles per countdown step (1 Hz at 100 MHz); range 2..2^27.
REQ-002 Parameter CYCLE_LEN, default 100; countdown steps per full light cycle; range 2..128.
REQ-003 Parameter SHORTEN_TO, default 10; countdown value forced by a pedestrian request; range 0..CYCLE_LEN-2.
REQ-004 clk  input  1  single system clock; all state is on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 en  input  1  level; 1 = run, 0 = freeze.
REQ-007 clr  input  1  synchronous restart of the cycle.
REQ-008 walk_req  input  1  pedestrian request; level or pulse, already synchronous to clk.
REQ-009 countdown  output  7  current cycle position; consumed by the state-to-light/display decode stage.
REQ-010 wrap  output  1  one-cycle pulse when countdown reloads from 0.
REQ-011 walk_ack  output  1  one-cycle pulse when a request shortens the cycle.

Function
REQ-012 FSM states: IDLE (after reset or clr), RUN, FREEZE.
REQ-013 Transitions: IDLE→RUN when en=1; RUN→FREEZE when en=0; FREEZE→RUN when en=1; any state→IDLE when clr=1.
REQ-014 Prescaler: counts 0..CLK_DIV-1 in RUN only; holds in FREEZE; zeroed in IDLE.
REQ-015 tick: internal one-cycle strobe asserted when the prescaler equals CLK_DIV-1 in RUN; the prescaler then returns to 0.
REQ-016 The first tick after entering RUN from IDLE occurs CLK_DIV cycles after the transition cycle.
REQ-017 On tick, when countdown > 0 and no shorten applies: countdown decrements by 1.
REQ-018 On tick, when countdown == 0: countdown reloads to CYCLE_LEN-1 and wrap = 1 on the following cycle (registered).
REQ-019 walk_pend: set on any cycle with walk_req=1 in RUN or FREEZE; ignored in IDLE.
REQ-020 Shorten: on tick, when walk_pend=1 and countdown > SHORTEN_TO, countdown loads SHORTEN_TO instead of decrementing.
REQ-021 On shorten, walk_pend clears and walk_ack = 1 on the following cycle.
REQ-022 When walk_pend=1 and countdown <= SHORTEN_TO: normal decrement or wrap; walk_pend is kept and is applied at the first qualifying tick after wrap.
REQ-023 Simultaneous tick with countdown==0 and walk_pend=1: wrap has priority; no ack.
REQ-024 Priority order: rst_n > clr > tick actions > hold.
REQ-025 clr: countdown = CYCLE_LEN-1, prescaler = 0, walk_pend = 0, wrap = 0, walk_ack = 0, next state IDLE, even while en=1.
REQ-026 In FREEZE, countdown, prescaler and walk_pend hold their values; no pulses are generated.
REQ-027 countdown never exceeds CYCLE_LEN-1; all arithmetic is unsigned 7-bit with no wrap other than the defined reload.

Reset
REQ-028 rst_n=0 asynchronously forces: state IDLE, countdown = CYCLE_LEN-1, prescaler 0, walk_pend 0, wrap 0, walk_ack 0.
REQ-029 Mid-operation reset discards a pending request and any partial prescale count.
REQ-030 Release of rst_n is synchronous to clk; the first state evaluation occurs on the first rising edge after release.

Structure
REQ-031 Shared package traffic_pkg holds: state encoding (IDLE/RUN/FREEZE), the color encodings RED=0/YELLOW=1/GREEN=2/OFF=3, and the default CYCLE_LEN/SHORTEN_TO values.
REQ-032 Prescaler is a sub-module tick_gen (clk, rst_n, run, zero, tick) parameterised by CLK_DIV.
REQ-033 The FSM, countdown register and request logic stay in traffic_timer; all outputs are registered.

Verification (CLK_DIV=4, CYCLE_LEN=8, SHORTEN_TO=3)
REQ-034 Reset release with en=1 held → countdown 7; steps 6,5,…,0 every 4 clk; then 7 with one wrap pulse; period 32 clk.
REQ-035 walk_req pulse at countdown=6 → next tick loads 3; walk_ack pulse; then 2,1,0,7.
REQ-036 walk_req at countdown=2 → 1,0,7 with wrap, no ack; next tick loads 3 with walk_ack.
REQ-037 en=0 for 10 clk at countdown=5 mid-prescale → value and prescale phase held; resume completes the remaining prescale count before 4.
REQ-038 clr asserted with en=1 at countdown=2 and walk_pend set → countdown 7, no ack ever issued; IDLE then RUN; first step after 4 clk.
REQ-039 rst_n pulsed low between clock edges at countdown=4 → immediate countdown 7 with outputs cleared, before the next clk edge.
